// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: queues event IDs in a small FIFO and expands each into a timed note sequence.
// Optional macro SFX_PREEMPT_EN: game-over (id 5) flushes the queue and preempts the current sequence.
module sfx_sequencer #(
    parameter int NOTE_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 250000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        evt_valid,
    input  logic [2:0]  evt_id,
    output logic        evt_ready,
    input  logic        mute,
    output logic        sfx_play,
    output logic [31:0] sfx_freq,
    output logic        busy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(NOTE_CYCLES - 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]     id_q, id_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           play_q, play_d;
    logic [31:0]    freq_q, freq_d;
    logic [2:0]     fifo_mem [FIFO_DEPTH];

    logic full, empty, push, preempt;

    function automatic logic [2:0] note_count(input logic [2:0] id);
        case (id)
            3'd0:    note_count = 3'd1;
            3'd1:    note_count = 3'd2;
            3'd2:    note_count = 3'd2;
            3'd3:    note_count = 3'd3;
            3'd4:    note_count = 3'd4;
            3'd5:    note_count = 3'd4;
            default: note_count = 3'd0;
        endcase
    endfunction

    // Unused slots return 1 Hz so the consumer never divides by zero.
    function automatic logic [31:0] note_freq(input logic [2:0] id, input logic [1:0] idx);
        note_freq = 32'd1;
        case (id)
            3'd0: note_freq = 32'd880;
            3'd1: note_freq = (idx == 2'd0) ? 32'd1047 : 32'd1319;
            3'd2: note_freq = (idx == 2'd0) ? 32'd220 : 32'd165;
            3'd3, 3'd4: begin
                case (idx)
                    2'd0:    note_freq = 32'd523;
                    2'd1:    note_freq = 32'd659;
                    2'd2:    note_freq = 32'd784;
                    default: note_freq = 32'd1047;
                endcase
            end
            3'd5: begin
                case (idx)
                    2'd0:    note_freq = 32'd392;
                    2'd1:    note_freq = 32'd330;
                    2'd2:    note_freq = 32'd262;
                    default: note_freq = 32'd196;
                endcase
            end
            default: note_freq = 32'd1;
        endcase
    endfunction

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef SFX_PREEMPT_EN
    assign preempt   = evt_valid && (evt_id == 3'd5);
    assign evt_ready = !full || preempt;
`else
    assign preempt   = 1'b0;
    assign evt_ready = !full;
`endif

    // A preempting id 5 bypasses the queue entirely.
    assign push = evt_valid && evt_ready && !preempt;
    assign busy = (state_q != S_IDLE) || !empty;

    assign sfx_play = play_q;
    assign sfx_freq = freq_q;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        play_d   = 1'b0;
        freq_d   = freq_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d  = S_LOAD;
                    id_d     = fifo_mem[rd_ptr_q[AW-1:0]];
                    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
                end
            end
            S_LOAD: begin
                idx_d = 2'd0;
                if (note_count(id_q) == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FIRE;
                    freq_d  = note_freq(id_q, 2'd0);
                    play_d  = !mute;
                end
            end
            S_FIRE: begin
                cnt_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (({1'b0, idx_q} + 3'd1) < note_count(id_q)) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_FIRE;
                        freq_d  = note_freq(id_q, idx_q + 2'd1);
                        play_d  = !mute;
                    end else if (GAP_CYCLES > 0) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (preempt) begin
            state_d  = S_LOAD;
            id_d     = 3'd5;
            idx_d    = 2'd0;
            play_d   = 1'b0;
            freq_d   = freq_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            id_q     <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            play_q   <= 1'b0;
            freq_q   <= 32'd1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            id_q     <= id_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            play_q   <= play_d;
            freq_q   <= freq_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= evt_id;
        end
    end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Upstream feeder for the audio block's sound-effect path. Game logic posts event IDs such as move, rotate, drop, line clear and game over.
- The block queues events in a small FIFO and expands each one into a fixed note sequence.
- Each note is driven as a one-cycle sfx_play pulse with a matching sfx_freq value in Hz.
- The consumer divides 25,000,000 by sfx_freq and plays each note for 6,250,000 cycles, so sfx_freq must never be 0.

Parameters:
- NOTE_CYCLES, 6250000: cycles between successive sfx_play pulses within a sequence. Must be ≥ 2.
- GAP_CYCLES, 250000: silent cycles after a sequence's last note before the next event is popped. 0 means no gap.
- FIFO_DEPTH, 4: event queue depth. Must be a power of 2 and ≥ 2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous reset, active-low.
- evt_valid  in  1  event request, held until accepted.
- evt_id  in  3  event code (see table).
- evt_ready  out  1  FIFO not full. Handshake completes when evt_valid && evt_ready at a rising edge.
- mute  in  1  suppresses sfx_play pulses only.
- sfx_play  out  1  registered one-cycle note-start pulse.
- sfx_freq  out  32  registered note frequency in Hz.
- busy  out  1  high when state ≠ IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async, resetn=0):
  - FIFO empty, state IDLE, counters 0.
  - Outputs: sfx_play=0, sfx_freq=32'd1, busy=0, evt_ready=1.
  - Release is sampled synchronously at the first edge with resetn=1.
- Event table (id: notes in Hz):
  - 0 move: 880
  - 1 rotate: 1047, 1319
  - 2 drop: 220, 165
  - 3 line clear: 523, 659, 784
  - 4 four-line clear: 523, 659, 784, 1047
  - 5 game over: 392, 330, 262, 196
  - 6, 7 reserved: zero notes. Accepted, then discarded.
- FIFO:
  - evt_ready = !full, combinational from pointers. No write-through when full, even if a pop occurs in the same cycle.
  - Push on handshake; pop only in IDLE→LOAD.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- State machine:
  - IDLE: if FIFO non-empty → LOAD, popping the head.
  - LOAD: latch id, note_idx=0, note_count from table. If note_count==0 → IDLE; else → FIRE.
  - FIRE (1 cycle):
    - sfx_freq ← table[id][note_idx].
    - sfx_play ← !mute for exactly this cycle.
    - cnt ← 0; → HOLD.
  - HOLD: stays NOTE_CYCLES-1 cycles, so consecutive FIRE edges are exactly NOTE_CYCLES apart. On expiry:
    - if note_idx+1 < note_count: note_idx++ → FIRE;
    - else if GAP_CYCLES>0: → GAP;
    - else: → IDLE.
  - GAP: stays GAP_CYCLES cycles → IDLE.
- Latency: with the block idle and the FIFO empty, for a handshake at edge 0:
  - FIFO non-empty after edge 0;
  - LOAD at edge 1;
  - FIRE at edge 2, so sfx_play is high between edges 2 and 3.
- sfx_freq holds its last value between notes. mute does not alter timing or sfx_freq updates.
- Events arriving mid-sequence queue behind it. Sequences are never interleaved.
- Simultaneous push and pop (not full): both occur; occupancy is unchanged.
- Reset mid-operation: everything returns to reset values immediately, and queued events are lost.

Optional Feature:
- Macro: SFX_PREEMPT_EN.
- Defined: a handshake with evt_id==5 in any state does the following at that edge:
  - flushes the FIFO;
  - aborts the current sequence;
  - forces LOAD of id 5 at the next edge, so FIRE occurs 2 edges after the handshake.
  - evt_ready is forced high for id 5 even when full.
- Undefined: id 5 is queued like any other event.

Test Plan (NOTE_CYCLES=8, GAP_CYCLES=4, FIFO_DEPTH=4):
1. Assert resetn=0 → sfx_play=0, sfx_freq=1, busy=0, evt_ready=1 immediately, without a clock.
2. Idle block, id1 accepted at edge 0 → pulses at edge 2 (1047) and edge 10 (1319); GAP entered edge 18; IDLE and busy=0 at edge 22.
3. Five back-to-back id0 events while a id4 plays → first four accepted, evt_ready=0 on the fifth. Played pulses at 523, 659, 784, 1047, then four 880 pulses, each 8 cycles apart within a sequence and 8+4+2 between sequences.
4. id6 alone → no sfx_play pulse; sfx_freq unchanged; busy low by edge 3.
5. mute=1, id3 → sfx_play never high; sfx_freq reads 523, 659, 784 after edges 2, 10, 18.
6. resetn pulsed low during HOLD of id5 note 2 with 2 events queued → immediate reset values; no pulses after release.
7. (SFX_PREEMPT_EN) During id3 note 1, with FIFO full, id5 is accepted → evt_ready=1 on that cycle; 392 pulse 2 edges later; queued events are never played.
